// File: rtl/dualmem_port_arb.sv
// Round-robin share of dualmem port A between two requesters, plus a zero-fill engine.
// Grant and address mux are combinational; read data returns 1 cycle after grant; no ready while filling.
module dualmem_port_arb #(
  parameter int ADDR_WIDTH     = 11,
  parameter int DATA_WIDTH     = 64,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    init_start,
  output logic                    init_busy,
  input  logic                    req0_valid,
  output logic                    req0_ready,
  input  logic [ADDR_WIDTH-1:0]   req0_addr,
  input  logic [DATA_WIDTH/8-1:0] req0_we,
  input  logic [DATA_WIDTH-1:0]   req0_wdata,
  output logic                    rsp0_valid,
  output logic [DATA_WIDTH-1:0]   rsp0_rdata,
  input  logic                    req1_valid,
  output logic                    req1_ready,
  input  logic [ADDR_WIDTH-1:0]   req1_addr,
  input  logic [DATA_WIDTH/8-1:0] req1_we,
  input  logic [DATA_WIDTH-1:0]   req1_wdata,
  output logic                    rsp1_valid,
  output logic [DATA_WIDTH-1:0]   rsp1_rdata,
  output logic                    mem_en,
  output logic [DATA_WIDTH/8-1:0] mem_we,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  input  logic [DATA_WIDTH-1:0]   mem_rdata
);

  typedef enum logic {CLEAR, ARB} state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] clr_cnt;
  logic                  rr_ptr;
  logic                  arb_ok;
  logic                  gnt0;
  logic                  gnt1;

  // rstn gates the combinational outputs so nothing reaches the RAM while held in reset.
  assign arb_ok = rstn && (state == ARB) && !init_start;
  assign gnt0   = arb_ok && req0_valid && (!req1_valid || !rr_ptr);
  assign gnt1   = arb_ok && req1_valid && (!req0_valid || rr_ptr);

  assign req0_ready = gnt0;
  assign req1_ready = gnt1;
  assign rsp0_rdata = mem_rdata;
  assign rsp1_rdata = mem_rdata;

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = '0;
    mem_addr  = req0_addr;
    mem_wdata = req0_wdata;
    if (rstn && state == CLEAR) begin
      mem_en    = 1'b1;
      mem_we    = '1;
      mem_addr  = clr_cnt;
      mem_wdata = '0;
    end else if (gnt1) begin
      mem_en    = 1'b1;
      mem_we    = req1_we;
      mem_addr  = req1_addr;
      mem_wdata = req1_wdata;
    end else if (gnt0) begin
      mem_en    = 1'b1;
      mem_we    = req0_we;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= (CLEAR_ON_RESET != 0) ? CLEAR : ARB;
      init_busy  <= (CLEAR_ON_RESET != 0);
      clr_cnt    <= '0;
      rr_ptr     <= 1'b0;
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
    end else begin
      rsp0_valid <= gnt0 && (req0_we == '0);
      rsp1_valid <= gnt1 && (req1_we == '0);
      if (gnt0) begin
        rr_ptr <= 1'b1;
      end else if (gnt1) begin
        rr_ptr <= 1'b0;
      end
      if (state == CLEAR) begin
        // Counter wraps back to zero on the final write, ready for the next fill.
        clr_cnt <= clr_cnt + ADDR_WIDTH'(1);
        if (&clr_cnt) begin
          state     <= ARB;
          init_busy <= 1'b0;
        end
      end else if (init_start) begin
        state     <= CLEAR;
        init_busy <= 1'b1;
        clr_cnt   <= '0;
      end
    end
  end

endmodule

// File: tb/tb_dualmem_port_arb.sv
// Self-checking bench for dualmem_port_arb: vector table, reference-model random traffic and fill/reset sequences.
module tb_dualmem_port_arb;
  localparam int AW    = 11;
  localparam int DW    = 64;
  localparam int BW    = 8;
  localparam int DEPTH = 2048;

  logic          clk = 1'b0;
  logic          rstn;
  logic          init_start;
  logic          init_busy;
  logic          req0_valid, req0_ready, rsp0_valid;
  logic [AW-1:0] req0_addr;
  logic [BW-1:0] req0_we;
  logic [DW-1:0] req0_wdata, rsp0_rdata;
  logic          req1_valid, req1_ready, rsp1_valid;
  logic [AW-1:0] req1_addr;
  logic [BW-1:0] req1_we;
  logic [DW-1:0] req1_wdata, rsp1_rdata;
  logic          mem_en;
  logic [BW-1:0] mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  dualmem_port_arb #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CLEAR_ON_RESET(1)) dut (
    .clk(clk), .rstn(rstn), .init_start(init_start), .init_busy(init_busy),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_addr(req0_addr),
    .req0_we(req0_we), .req0_wdata(req0_wdata), .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_addr(req1_addr),
    .req1_we(req1_we), .req1_wdata(req1_wdata), .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Stand-in for dualmem port A: byte-writable, read-first, 1-cycle read latency.
  logic [DW-1:0] ram [DEPTH];
  always @(posedge clk) begin
    if (mem_en) begin
      mem_rdata <= ram[mem_addr];
      for (int b = 0; b < BW; b++)
        if (mem_we[b]) ram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
    end
  end

  int            checks = 0;
  int            passed = 0;
  logic [DW-1:0] ref_mem [DEPTH];
  int            last_gnt;

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %b, expected %b", name, act, exp);
  endtask

  task automatic chkw(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit v0, input logic [AW-1:0] a0, input logic [BW-1:0] w0, input logic [DW-1:0] d0,
                       input bit v1, input logic [AW-1:0] a1, input logic [BW-1:0] w1, input logic [DW-1:0] d1,
                       input bit st);
    req0_valid = v0; req0_addr = a0; req0_we = w0; req0_wdata = d0;
    req1_valid = v1; req1_addr = a1; req1_we = w1; req1_wdata = d1;
    init_start = st;
  endtask

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] nw, input logic [BW-1:0] be);
    logic [DW-1:0] r;
    r = old;
    for (int b = 0; b < BW; b++)
      if (be[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  function automatic logic [BW-1:0] rnd_we();
    return ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom);
  endfunction

  // One ARB-state cycle checked against the reference model: whoever did not go last wins a tie.
  task automatic cyc(input bit v0, input logic [AW-1:0] a0, input logic [BW-1:0] w0, input logic [DW-1:0] d0,
                     input bit v1, input logic [AW-1:0] a1, input logic [BW-1:0] w1, input logic [DW-1:0] d1,
                     input bit st);
    int            g;
    logic [AW-1:0] ga;
    logic [BW-1:0] gw;
    logic [DW-1:0] gd, ed;
    bit            ev0, ev1;
    drive(v0, a0, w0, d0, v1, a1, w1, d1, st);
    #1;
    g = -1;
    if (!st) begin
      if (v0 && v1) g = (last_gnt == 0) ? 1 : 0;
      else if (v0)  g = 0;
      else if (v1)  g = 1;
    end
    chk1("req0_ready", req0_ready, g == 0);
    chk1("req1_ready", req1_ready, g == 1);
    ev0 = 0; ev1 = 0; ed = '0;
    if (g >= 0) begin
      ga = (g == 0) ? a0 : a1;
      gw = (g == 0) ? w0 : w1;
      gd = (g == 0) ? d0 : d1;
      chk1("mem_en_grant", mem_en, 1'b1);
      chkw("mem_addr", 64'(mem_addr), 64'(ga));
      chkw("mem_we", 64'(mem_we), 64'(gw));
      if (gw != '0) begin
        chkw("mem_wdata", mem_wdata, gd);
        ref_mem[ga] = merge(ref_mem[ga], gd, gw);
      end else begin
        ed = ref_mem[ga];
        if (g == 0) ev0 = 1; else ev1 = 1;
      end
      last_gnt = g;
    end else begin
      chk1("mem_en_idle", mem_en, 1'b0);
    end
    tick();
    chk1("rsp0_valid", rsp0_valid, ev0);
    chk1("rsp1_valid", rsp1_valid, ev1);
    if (ev0) chkw("rsp0_rdata", rsp0_rdata, ed);
    if (ev1) chkw("rsp1_rdata", rsp1_rdata, ed);
  endtask

  // Waits out a fill with both requesters pushing reads; the fill must write 0..2047 in order.
  task automatic wait_fill(input string tag);
    int n;
    bit rdy_seen, write_bad;
    n = 0; rdy_seen = 0; write_bad = 0;
    drive(1, 11'd3, 8'h00, 64'h0, 1, 11'd4, 8'h00, 64'h0, 0);
    while (init_busy === 1'b1 && n < 3000) begin
      #1;
      if (req0_ready !== 1'b0 || req1_ready !== 1'b0) rdy_seen = 1;
      if (mem_en !== 1'b1 || mem_we !== 8'hFF || mem_wdata !== 64'h0 || mem_addr !== AW'(n)) write_bad = 1;
      n++;
      tick();
    end
    chkw({tag, "_busy_cycles"}, 64'(n), 64'd2048);
    chk1({tag, "_ready_during_fill"}, rdy_seen, 1'b0);
    chk1({tag, "_fill_write_sequence_bad"}, write_bad, 1'b0);
    drive(0, 11'd0, 8'h00, 64'h0, 0, 11'd0, 8'h00, 64'h0, 0);
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
  endtask

  typedef struct {
    bit            v0;
    logic [AW-1:0] a0;
    logic [BW-1:0] w0;
    logic [DW-1:0] d0;
    bit            v1;
    logic [AW-1:0] a1;
    logic [BW-1:0] w1;
    logic [DW-1:0] d1;
    bit            r0, r1;
    bit            e0, e1;
    logic [DW-1:0] ed;
  } vec_t;

  vec_t tbl [14];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // Entries 0-6 leave the pointer favouring requester 0, so the six contended reads go 0,1,0,1,0,1.
    tbl[0]  = '{1, 11'd5,  8'hFF, 64'h0123456789ABCDEF, 0, 11'd0,  8'h00, 64'h0, 1, 0, 0, 0, 64'h0};
    tbl[1]  = '{1, 11'd5,  8'h00, 64'h0,                0, 11'd0,  8'h00, 64'h0, 1, 0, 1, 0, 64'h0123456789ABCDEF};
    tbl[2]  = '{1, 11'd7,  8'h0F, 64'hFFFFFFFFFFFFFFFF, 0, 11'd0,  8'h00, 64'h0, 1, 0, 0, 0, 64'h0};
    tbl[3]  = '{1, 11'd7,  8'h00, 64'h0,                0, 11'd0,  8'h00, 64'h0, 1, 0, 1, 0, 64'h00000000FFFFFFFF};
    tbl[4]  = '{1, 11'd10, 8'hFF, 64'h0A0A0A0A0A0A0A0A, 0, 11'd0,  8'h00, 64'h0, 1, 0, 0, 0, 64'h0};
    tbl[5]  = '{0, 11'd0,  8'h00, 64'h0,                1, 11'd20, 8'hFF, 64'h1414141414141414, 0, 1, 0, 0, 64'h0};
    tbl[6]  = '{0, 11'd0,  8'h00, 64'h0,                0, 11'd0,  8'h00, 64'h0, 0, 0, 0, 0, 64'h0};
    tbl[7]  = '{1, 11'd10, 8'h00, 64'h0, 1, 11'd20, 8'h00, 64'h0, 1, 0, 1, 0, 64'h0A0A0A0A0A0A0A0A};
    tbl[8]  = '{1, 11'd10, 8'h00, 64'h0, 1, 11'd20, 8'h00, 64'h0, 0, 1, 0, 1, 64'h1414141414141414};
    tbl[9]  = '{1, 11'd10, 8'h00, 64'h0, 1, 11'd20, 8'h00, 64'h0, 1, 0, 1, 0, 64'h0A0A0A0A0A0A0A0A};
    tbl[10] = '{1, 11'd10, 8'h00, 64'h0, 1, 11'd20, 8'h00, 64'h0, 0, 1, 0, 1, 64'h1414141414141414};
    tbl[11] = '{1, 11'd10, 8'h00, 64'h0, 1, 11'd20, 8'h00, 64'h0, 1, 0, 1, 0, 64'h0A0A0A0A0A0A0A0A};
    tbl[12] = '{1, 11'd10, 8'h00, 64'h0, 1, 11'd20, 8'h00, 64'h0, 0, 1, 0, 1, 64'h1414141414141414};
    tbl[13] = '{1, 11'd11, 8'hFF, 64'h5555AAAA5555AAAA, 1, 11'd20, 8'h00, 64'h0, 1, 0, 0, 0, 64'h0};

    for (int i = 0; i < DEPTH; i++) ram[i] <= {8{8'hA5}};
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    rstn = 1'b0;
    drive(1, 11'd1, 8'h00, 64'h0, 1, 11'd2, 8'h00, 64'h0, 0);
    #12;
    chk1("reset_init_busy", init_busy, 1'b1);
    chk1("reset_req0_ready", req0_ready, 1'b0);
    chk1("reset_req1_ready", req1_ready, 1'b0);
    chk1("reset_mem_en", mem_en, 1'b0);
    chkw("reset_mem_we", 64'(mem_we), 64'h0);
    chk1("reset_rsp0_valid", rsp0_valid, 1'b0);
    chk1("reset_rsp1_valid", rsp1_valid, 1'b0);
    tick();
    rstn = 1'b1;
    last_gnt = 1;
    wait_fill("por");

    cyc(1, 11'd0,    8'h00, 64'h0, 0, 11'd0, 8'h00, 64'h0, 0);
    cyc(1, 11'd1023, 8'h00, 64'h0, 0, 11'd0, 8'h00, 64'h0, 0);
    cyc(1, 11'd2047, 8'h00, 64'h0, 0, 11'd0, 8'h00, 64'h0, 0);

    foreach (tbl[i]) begin
      drive(tbl[i].v0, tbl[i].a0, tbl[i].w0, tbl[i].d0, tbl[i].v1, tbl[i].a1, tbl[i].w1, tbl[i].d1, 0);
      #1;
      chk1($sformatf("vec%0d_req0_ready", i), req0_ready, tbl[i].r0);
      chk1($sformatf("vec%0d_req1_ready", i), req1_ready, tbl[i].r1);
      tick();
      chk1($sformatf("vec%0d_rsp0_valid", i), rsp0_valid, tbl[i].e0);
      chk1($sformatf("vec%0d_rsp1_valid", i), rsp1_valid, tbl[i].e1);
      if (tbl[i].e0) chkw($sformatf("vec%0d_rsp0_rdata", i), rsp0_rdata, tbl[i].ed);
      if (tbl[i].e1) chkw($sformatf("vec%0d_rsp1_rdata", i), rsp1_rdata, tbl[i].ed);
    end

    // Random traffic on addresses the table never touched (still zero after the fill).
    last_gnt = 0;
    for (int k = 0; k < 300; k++) begin
      cyc(1'($urandom_range(0, 1)), AW'(100 + $urandom_range(0, 15)), rnd_we(), {$urandom, $urandom},
          1'($urandom_range(0, 1)), AW'(100 + $urandom_range(0, 15)), rnd_we(), {$urandom, $urandom}, 0);
    end

    cyc(1, 11'd30, 8'hFF, 64'hDEADBEEFCAFEF00D, 0, 11'd0, 8'h00, 64'h0, 0);
    cyc(1, 11'd30, 8'h00, 64'h0, 0, 11'd0, 8'h00, 64'h0, 0);
    cyc(1, 11'd30, 8'h00, 64'h0, 1, 11'd31, 8'h00, 64'h0, 1);
    chk1("init_start_busy", init_busy, 1'b1);
    wait_fill("cmd");
    cyc(1, 11'd30, 8'h00, 64'h0, 0, 11'd0, 8'h00, 64'h0, 0);
    cyc(0, 11'd0,  8'h00, 64'h0, 1, 11'd5, 8'h00, 64'h0, 0);

    cyc(0, 11'd0, 8'h00, 64'h0, 0, 11'd0, 8'h00, 64'h0, 1);
    drive(1, 11'd9, 8'h00, 64'h0, 1, 11'd9, 8'h00, 64'h0, 0);
    repeat (1000) tick();
    chkw("fill_addr_1000", 64'(mem_addr), 64'd1000);
    chk1("fill_mem_en_1000", mem_en, 1'b1);
    rstn = 1'b0;
    #1;
    chk1("midrst_mem_en", mem_en, 1'b0);
    chkw("midrst_mem_we", 64'(mem_we), 64'h0);
    chk1("midrst_req0_ready", req0_ready, 1'b0);
    chk1("midrst_req1_ready", req1_ready, 1'b0);
    chk1("midrst_init_busy", init_busy, 1'b1);
    chk1("midrst_rsp0_valid", rsp0_valid, 1'b0);
    tick();
    tick();
    rstn = 1'b1;
    last_gnt = 1;
    wait_fill("rst");
    cyc(1, 11'd10, 8'h00, 64'h0, 1, 11'd20, 8'h00, 64'h0, 0);
    cyc(1, 11'd10, 8'h00, 64'h0, 1, 11'd20, 8'h00, 64'h0, 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/dualmem_port_arb.md
Name: dualmem_port_arb

Overview:
- Shares one port (A) of the 2048 x 64-bit byte-writable dual-port BRAM (`dualmem`) between two requesters with a round-robin valid/ready protocol.
- Returns read data with the RAM's fixed 1-cycle latency.
- Owns a zero-fill engine that clears the whole array after reset, or on command, before any requester is served.
- Sits between the boot/debug loader (requester 0), the core-side bus adapter (requester 1) and `dualmem` port A.

Parameters:
- ADDR_WIDTH, 11, word address width (depth = 2**ADDR_WIDTH words)
- DATA_WIDTH, 64, data width; byte-enable width = DATA_WIDTH/8
- CLEAR_ON_RESET, 1, 1 = run the zero-fill automatically after reset release; 0 = come up in ARB

Ports:
- clk  in  1  clock, also drives `dualmem` clka
- rstn  in  1  asynchronous active-low reset
- init_start  in  1  single-cycle pulse: begin zero-fill
- init_busy  out  1  zero-fill in progress
- req0_valid  in  1  requester 0 command valid
- req0_ready  out  1  requester 0 command accepted this cycle
- req0_addr  in  ADDR_WIDTH  word address
- req0_we  in  DATA_WIDTH/8  byte write enables; all zero = read
- req0_wdata  in  DATA_WIDTH  write data
- rsp0_valid  out  1  read data valid for requester 0
- rsp0_rdata  out  DATA_WIDTH  read data
- req1_valid, req1_ready, req1_addr, req1_we, req1_wdata, rsp1_valid, rsp1_rdata: same as requester 0, for requester 1
- mem_en  out  1  to `dualmem` ena
- mem_we  out  DATA_WIDTH/8  to wea
- mem_addr  out  ADDR_WIDTH  to addra
- mem_wdata  out  DATA_WIDTH  to dina
- mem_rdata  in  DATA_WIDTH  from douta

Behaviour:
- Clock and reset: single clock clk; rstn is asynchronous, active-low.
- Reset values:
  - init_busy = CLEAR_ON_RESET
  - rsp*_valid = 0
  - round-robin pointer = 0
  - clear counter = 0
  - state = CLEAR if CLEAR_ON_RESET, else ARB
- Combinational outputs during reset: req*_ready = 0, mem_en = 0, mem_we = 0.
- States: CLEAR, ARB.
- CLEAR:
  - Each cycle: mem_en = 1, mem_we = all ones, mem_wdata = 0, mem_addr = clear counter; counter then increments.
  - After writing address 2**ADDR_WIDTH-1, go to ARB and deassert init_busy next cycle. The fill takes exactly 2**ADDR_WIDTH cycles.
  - req*_ready = 0 throughout; init_start is ignored.
- ARB:
  - Transitions: init_start = 1 -> CLEAR with counter = 0. That cycle grants nothing; mem_en = 0.
  - Grant rule:
    - only reqN_valid set -> grant N
    - both set -> grant the requester the pointer indicates
    - after any grant, the pointer = the other requester
  - reqN_ready is combinational: reqN_ready = state==ARB && !init_start && granted N. At most one ready is high per cycle.
  - On grant: mem_en = 1, and mem_addr/mem_we/mem_wdata come from the granted requester (combinational mux, no added latency).
  - Throughput: one command per cycle, back-to-back, no bubbles.
- Read response:
  - A granted read (reqN_we == 0) sets rspN_valid = 1 for exactly the following cycle.
  - rspN_rdata = mem_rdata, passed through combinationally. rdata is don't-care when valid = 0.
  - Writes produce no response; the ready handshake completes them.
- Ordering: responses return in grant order; a read issued the cycle after a write to the same address returns the new data.
- Reset mid-CLEAR: aborts immediately. After release the fill restarts from address 0 (when CLEAR_ON_RESET = 1).
- A read granted in the last ARB cycle before CLEAR still gets its rsp_valid in the following cycle.
- Port B of `dualmem` is outside this block and is not arbitrated here.

Test Plan:
- Reset with CLEAR_ON_RESET = 1, having first backdoor-filled the RAM with 0xA5 bytes:
  - init_busy must be high for exactly 2048 cycles.
  - Reads of addresses 0, 1023 and 2047 must return 64'h0.
  - req*_ready must be 0 throughout the fill.
- Requester 0 only, back-to-back:
  - Write 64'h0123456789ABCDEF to address 5, then read address 5.
  - Read must be accepted the very next cycle; rsp0_valid must rise one cycle after the read grant with that exact data.
- Byte-enable write:
  - Write 64'hFFFF_FFFF_FFFF_FFFF to address 7 with we = 8'h0F, over 64'h0.
  - Read back of address 7 must return 64'h00000000FFFFFFFF.
- Both requesters hold valid reads for 6 cycles (req0 to address 10, req1 to address 20):
  - Grants must follow 0,1,0,1,0,1.
  - Each rspN_valid must assert only in the cycle after its own grant, with the correct data.
- init_start pulsed while both requesters are valid:
  - No grant in that cycle; init_busy must go high for 2048 cycles.
  - Earlier nonzero data must read back as 0 afterwards.
  - A read granted in the cycle before init_start must still deliver rsp_valid.
- rstn asserted at fill cycle 1000:
  - Outputs must immediately take their reset values.
  - After release, the fill must restart at address 0 and last the full 2048 cycles.
